program_loader: RTL and testbench

- Boot-time loader upstream of the CPU core.
- Receives a byte stream (UART RX style, valid/ready) carrying a program image and assembles little-endian 32-bit instructions.
- Writes each instruction into instruction memory through the core's dbg_wr_en / dbg_addr / dbg_instr write port.
- Holds the core in reset (core_rst) until the whole image is loaded, then releases it.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/program_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_program_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
//   Shared types and constants for the boot-time program loader.
//   - loader_state_t : loader FSM states
//   - HDR_BYTES      : bytes in the little-endian word-count header
//   - BYTES_PER_WORD : stream bytes per instruction word (default geometry)
// -----------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR_LO,
      HDR_HI,
      DATA,
      WRITE,
      DONE,
      ERROR
   } loader_state_t;

   localparam int XLEN_DEFAULT       = 32;
   localparam int BYTE_WIDTH_DEFAULT = 8;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = XLEN_DEFAULT / BYTE_WIDTH_DEFAULT;

endpackage

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Boot-time loader sitting upstream of the CPU core. Consumes a byte stream
//   (valid/ready) holding a 16-bit word count followed by that many
//   little-endian instruction words, writes each word into instruction memory
//   through the core's debug write port, and keeps the core in reset until the
//   whole image has been written.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   rx_valid   in   stream byte valid
//   rx_data    in   stream byte
//   rx_ready   out  loader accepts a byte this cycle (decode of state)
//   start      in   single-cycle pulse; restarts loading from DONE or ERROR
//   dbg_wr_en  out  instruction memory write strobe (one cycle per word)
//   dbg_addr   out  instruction memory byte address
//   dbg_instr  out  instruction word
//   core_rst   out  active-high reset to the core
//   load_done  out  image loaded, core running
//   load_error out  bad header or inter-byte timeout
// -----------------------------------------------------------------------------
module program_loader
   import loader_pkg::*;
#(
   parameter int XLEN           = XLEN_DEFAULT,
   parameter int BYTE_WIDTH     = BYTE_WIDTH_DEFAULT,
   parameter int MAX_WORDS      = 256,
   parameter int TIMEOUT_CYCLES = 100000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [BYTE_WIDTH-1:0] rx_data,
   output logic                  rx_ready,
   input  logic                  start,
   output logic                  dbg_wr_en,
   output logic [XLEN-1:0]       dbg_addr,
   output logic [XLEN-1:0]       dbg_instr,
   output logic                  core_rst,
   output logic                  load_done,
   output logic                  load_error
);

   localparam int L_BPW    = XLEN / BYTE_WIDTH;
   localparam int L_BIDX_W = (L_BPW > 1) ? $clog2(L_BPW) : 1;
   localparam int L_ADDR_SH = $clog2(L_BPW);
   localparam int L_CNT_W  = HDR_BYTES * BYTE_WIDTH;
   localparam int L_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   loader_state_t          r_state,      r_state_next;
   logic [L_CNT_W-1:0]     r_count,      r_count_next;
   logic [L_CNT_W-1:0]     r_word_idx,   r_word_idx_next;
   logic [L_BIDX_W-1:0]    r_byte_idx,   r_byte_idx_next;
   logic [XLEN-1:0]        r_shift,      r_shift_next;
   logic [L_TO_W-1:0]      r_timeout,    r_timeout_next;
   logic                   r_wr_en,      r_wr_en_next;
   logic [XLEN-1:0]        r_addr,       r_addr_next;
   logic [XLEN-1:0]        r_instr,      r_instr_next;
   logic                   r_core_rst,   r_core_rst_next;
   logic                   r_load_done,  r_load_done_next;
   logic                   r_load_error, r_load_error_next;

   logic                   w_rx_ready;
   logic                   w_accept;
   logic [L_CNT_W-1:0]     w_hdr_count;
   logic                   w_hdr_bad;
   logic [XLEN-1:0]        w_shift_in;
   logic                   w_to_expired;
   logic                   w_last_byte;
   logic                   w_last_word;

   assign w_rx_ready = (r_state == HDR_LO) || (r_state == HDR_HI) || (r_state == DATA);
   assign w_accept   = rx_valid && w_rx_ready;

   // Full count as it will be once the high header byte lands this cycle.
   assign w_hdr_count = {rx_data, r_count[BYTE_WIDTH-1:0]};
   assign w_hdr_bad   = (w_hdr_count == '0) || (int'(w_hdr_count) > MAX_WORDS);

   // Bytes enter at the top and move down, so after a full word the first
   // byte received sits in the least significant lane.
   assign w_shift_in  = {rx_data, r_shift[XLEN-1:BYTE_WIDTH]};
   assign w_last_byte = (r_byte_idx == L_BIDX_W'(L_BPW - 1));
   assign w_last_word = (r_word_idx == (r_count - L_CNT_W'(1)));

   // The accept check is deliberate: a byte arriving on the final allowed
   // cycle still counts as activity.
   assign w_to_expired = (r_timeout == L_TO_W'(TIMEOUT_CYCLES - 1)) && !w_accept;

   // ---------------------------------------------------------------------
   // Next-state and registered-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      r_state_next      = r_state;
      r_count_next      = r_count;
      r_word_idx_next   = r_word_idx;
      r_byte_idx_next   = r_byte_idx;
      r_shift_next      = r_shift;
      r_timeout_next    = r_timeout;
      r_wr_en_next      = 1'b0;
      r_addr_next       = r_addr;
      r_instr_next      = r_instr;
      r_core_rst_next   = r_core_rst;
      r_load_done_next  = r_load_done;
      r_load_error_next = r_load_error;

      case (r_state)
         IDLE: begin
            r_state_next = HDR_LO;
         end

         HDR_LO: begin
            if (w_accept) begin
               r_count_next[BYTE_WIDTH-1:0] = rx_data;
               r_timeout_next               = '0;
               r_state_next                 = HDR_HI;
            end
         end

         HDR_HI: begin
            if (w_accept) begin
               r_count_next   = w_hdr_count;
               r_timeout_next = '0;
               if (w_hdr_bad) begin
                  r_state_next      = ERROR;
                  r_load_error_next = 1'b1;
               end else begin
                  r_state_next    = DATA;
                  r_word_idx_next = '0;
                  r_byte_idx_next = '0;
               end
            end else if (w_to_expired) begin
               r_state_next      = ERROR;
               r_load_error_next = 1'b1;
            end else begin
               r_timeout_next = r_timeout + L_TO_W'(1);
            end
         end

         DATA: begin
            if (w_accept) begin
               r_shift_next    = w_shift_in;
               r_byte_idx_next = r_byte_idx + L_BIDX_W'(1);
               r_timeout_next  = '0;
               if (w_last_byte) begin
                  r_state_next = WRITE;
                  r_wr_en_next = 1'b1;
                  r_instr_next = w_shift_in;
                  r_addr_next  = XLEN'(r_word_idx) << L_ADDR_SH;
               end
            end else if (w_to_expired) begin
               r_state_next      = ERROR;
               r_load_error_next = 1'b1;
            end else begin
               r_timeout_next = r_timeout + L_TO_W'(1);
            end
         end

         WRITE: begin
            if (w_last_word) begin
               r_state_next     = DONE;
               r_core_rst_next  = 1'b0;
               r_load_done_next = 1'b1;
            end else begin
               r_word_idx_next = r_word_idx + L_CNT_W'(1);
               r_timeout_next  = '0;
               r_state_next    = DATA;
            end
         end

         DONE: begin
            if (start) begin
               r_state_next     = HDR_LO;
               r_core_rst_next  = 1'b1;
               r_load_done_next = 1'b0;
            end
         end

         ERROR: begin
            // Words already written stay in memory; the core stays in reset.
            if (start) begin
               r_state_next      = HDR_LO;
               r_load_error_next = 1'b0;
            end
         end

         default: begin
            r_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_count      <= '0;
         r_word_idx   <= '0;
         r_byte_idx   <= '0;
         r_shift      <= '0;
         r_timeout    <= '0;
         r_wr_en      <= 1'b0;
         r_addr       <= '0;
         r_instr      <= '0;
         r_core_rst   <= 1'b1;
         r_load_done  <= 1'b0;
         r_load_error <= 1'b0;
      end else begin
         r_state      <= r_state_next;
         r_count      <= r_count_next;
         r_word_idx   <= r_word_idx_next;
         r_byte_idx   <= r_byte_idx_next;
         r_shift      <= r_shift_next;
         r_timeout    <= r_timeout_next;
         r_wr_en      <= r_wr_en_next;
         r_addr       <= r_addr_next;
         r_instr      <= r_instr_next;
         r_core_rst   <= r_core_rst_next;
         r_load_done  <= r_load_done_next;
         r_load_error <= r_load_error_next;
      end
   end

   assign rx_ready   = w_rx_ready;
   assign dbg_wr_en  = r_wr_en;
   assign dbg_addr   = r_addr;
   assign dbg_instr  = r_instr;
   assign core_rst   = r_core_rst;
   assign load_done  = r_load_done;
   assign load_error = r_load_error;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Self-checking bench for program_loader. A high-level model (queue of
//   expected memory writes derived from the image) is checked by a monitor on
//   every negative clock edge; directed scenarios add literal expectations for
//   reset values, error handling, timeout distance and restart behaviour.
// -----------------------------------------------------------------------------
module tb_program_loader;

   localparam int TO   = 16;
   localparam int MAXW = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        start = 1'b0;
   logic        rx_ready;
   logic        dbg_wr_en;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_instr;
   logic        core_rst;
   logic        load_done;
   logic        load_error;

   program_loader #(
      .XLEN           (32),
      .BYTE_WIDTH     (8),
      .MAX_WORDS      (MAXW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .start      (start),
      .dbg_wr_en  (dbg_wr_en),
      .dbg_addr   (dbg_addr),
      .dbg_instr  (dbg_instr),
      .core_rst   (core_rst),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_instr[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_instr[$];
   logic [31:0] ref_addr[$];
   logic [31:0] ref_instr[$];
   logic [31:0] img[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Monitor: every write must match the next expected one from the model.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_vs_done", {31'b0, core_rst}, {31'b0, ~load_done});
         if (dbg_wr_en) begin
            log_addr.push_back(dbg_addr);
            log_instr.push_back(dbg_instr);
            $display("write addr=0x%08h instr=0x%08h", dbg_addr, dbg_instr);
            check("ready_in_write", {31'b0, rx_ready}, 32'd0);
            if (exp_addr.size() == 0) begin
               check("unexpected_wr", 32'(exp_addr.size()), 32'd1);
            end else begin
               check("wr_addr",  dbg_addr,  exp_addr.pop_front());
               check("wr_instr", dbg_instr, exp_instr.pop_front());
            end
         end
      end
   end

   // Tasks start and end just after a negative edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      waited   = 0;
      while (!rx_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!rx_ready) check("accept_wait", 32'(waited), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_rx_ready",   {31'b0, rx_ready},   32'd0);
      check("rst_wr_en",      {31'b0, dbg_wr_en},  32'd0);
      check("rst_addr",       dbg_addr,            32'd0);
      check("rst_instr",      dbg_instr,           32'd0);
      check("rst_core_rst",   {31'b0, core_rst},   32'd1);
      check("rst_load_done",  {31'b0, load_done},  32'd0);
      check("rst_load_error", {31'b0, load_error}, 32'd0);
   endtask

   // Streams img[] as a complete image; the model expects write i at byte
   // address 4*i carrying img[i].
   task automatic load_image(input int max_gap);
      int          n;
      logic [15:0] nn;
      logic [31:0] w;
      n  = img.size();
      nn = 16'(n);
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(32'(i * 4));
         exp_instr.push_back(img[i]);
      end
      send_byte(nn[7:0],  (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
      send_byte(nn[15:8], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int k = 0; k < 4; k++) begin
            send_byte(8'((w >> (8 * k)) & 32'hFF),
                      (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
         end
         check("wr_pulse", {31'b0, dbg_wr_en}, 32'd1);
         if (i == n - 1) check("core_rst_at_last", {31'b0, core_rst}, 32'd1);
      end
      @(negedge clk);
      check("done_core_rst",  {31'b0, core_rst},  32'd0);
      check("done_load_done", {31'b0, load_done}, 32'd1);
      check("model_drained",  32'(exp_addr.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      // Reset state
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b1;

      // Two-word reference image
      img = '{32'h00100513, 32'h00200593};
      load_image(0);
      check("lit_addr0",  log_addr[0],  32'h0000_0000);
      check("lit_instr0", log_instr[0], 32'h0010_0513);
      check("lit_addr1",  log_addr[1],  32'h0000_0004);
      check("lit_instr1", log_instr[1], 32'h0020_0593);
      start_pulse();
      check("restart_done",  {31'b0, load_done}, 32'd0);
      check("restart_crst",  {31'b0, core_rst},  32'd1);
      check("restart_ready", {31'b0, rx_ready},  32'd1);

      // Zero-length header
      log_addr.delete(); log_instr.delete();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("zero_error", {31'b0, load_error}, 32'd1);
      check("zero_crst",  {31'b0, core_rst},   32'd1);
      check("zero_ready", {31'b0, rx_ready},   32'd0);
      check("zero_writes", 32'(log_addr.size()), 32'd0);
      start_pulse();
      check("err_clear", {31'b0, load_error}, 32'd0);
      check("err_ready", {31'b0, rx_ready},   32'd1);

      // Oversize header (257 words)
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      check("over_error", {31'b0, load_error}, 32'd1);
      check("over_writes", 32'(log_addr.size()), 32'd0);
      start_pulse();

      // Largest legal image
      img.delete();
      for (int i = 0; i < MAXW; i++) img.push_back($urandom);
      load_image(0);
      check("max_count",     32'(log_addr.size()), 32'd256);
      check("max_last_addr", log_addr[log_addr.size() - 1], 32'h0000_03FC);
      start_pulse();

      // Timeout mid-word
      log_addr.delete(); log_instr.delete();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'($urandom), 0);
      send_byte(8'($urandom), 0);
      k = 0;
      while (!load_error && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("timeout_dist",   32'(k), 32'(TO));
      check("timeout_writes", 32'(log_addr.size()), 32'd0);
      check("timeout_crst",   {31'b0, core_rst}, 32'd1);
      start_pulse();

      // Gap-free versus gapped delivery of the same image
      img.delete();
      for (int i = 0; i < 4; i++) img.push_back($urandom);
      log_addr.delete(); log_instr.delete();
      load_image(0);
      ref_addr  = log_addr;
      ref_instr = log_instr;
      start_pulse();
      log_addr.delete(); log_instr.delete();
      load_image(8);
      check("gap_count", 32'(log_addr.size()), 32'(ref_addr.size()));
      for (int i = 0; i < 4; i++) begin
         check("gap_addr",  log_addr[i],  ref_addr[i]);
         check("gap_instr", log_instr[i], ref_instr[i]);
      end
      start_pulse();

      // Reset during the third byte of word 1
      img.delete();
      for (int i = 0; i < 3; i++) img.push_back($urandom);
      exp_addr.push_back(32'h0);
      exp_instr.push_back(img[0]);
      send_byte(8'h03, 0);
      send_byte(8'h00, 0);
      for (int b = 0; b < 4; b++) send_byte(8'((img[0] >> (8 * b)) & 32'hFF), 0);
      send_byte(8'(img[1] & 32'hFF), 0);
      send_byte(8'((img[1] >> 8) & 32'hFF), 0);
      rx_valid = 1'b1;
      rx_data  = 8'((img[1] >> 16) & 32'hFF);
      #2 rst = 1'b0;
      #1 check_reset_values();
      rx_valid = 1'b0;
      exp_addr.delete(); exp_instr.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      log_addr.delete(); log_instr.delete();
      load_image(0);
      check("reload_count",  32'(log_addr.size()), 32'd3);
      check("reload_addr0",  log_addr[0],  32'h0);
      check("reload_instr0", log_instr[0], img[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
